// File: rtl/game_pkg.sv
// Shared game definitions: state encoding seen by the graphics controller, bus widths.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package game_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int DEPTH_W  = 8;
  localparam int IDX_W    = 4;
  localparam int COUNT_W  = 20;
  // Step and countdown counters are 8 bits: FRAMES_PER_STEP and START_FRAMES must be <= 255.
  localparam int STEP_W   = 8;
  localparam int CDOWN_W  = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Codes are fixed: the graphics controller decodes this same enum.
  typedef enum logic [2:0] {
    GAME_OVER        = 3'd0,
    GAME_IN_PROGRESS = 3'd1,
    GAME_WIN         = 3'd2,
    GAME_START       = 3'd3
  } game_state_t;

  // |a - b| computed in one extra bit so the full 8-bit range cannot wrap.
  function automatic logic [DEPTH_W:0] depth_abs_diff(input logic [DEPTH_W-1:0] a,
                                                      input logic [DEPTH_W-1:0] b);
    logic [DEPTH_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DEPTH_W] ? (~d + 1'b1) : d;
  endfunction

endpackage

// File: rtl/collision_accumulator.sv
// Counts collision pixels inside the active area and latches the total at each frame end.
// Latency: frame_collisions_out and new_frame_out update 1 cycle after the frame-end pixel.
// Backpressure: none; free-running on the pixel stream, count saturates instead of wrapping.
module collision_accumulator
  import game_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                is_collision,
  output logic                frame_end,
  output logic                new_frame_out,
  output logic [COUNT_W-1:0]  frame_collisions_out
);

  logic               active;
  logic [COUNT_W-1:0] count_q;

  // The frame-end pixel lies in vertical blanking, so clearing the running count there never drops a hit.
  assign frame_end = (hcount_in == '0) && (vcount_in == VCOUNT_W'(ACTIVE_LINES));
  assign active    = (hcount_in < HCOUNT_W'(ACTIVE_H_PIXELS)) &&
                     (vcount_in < VCOUNT_W'(ACTIVE_LINES));

  // Running count, result latch and frame pulse; reset mid-frame simply restarts the count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q              <= '0;
      frame_collisions_out <= '0;
      new_frame_out        <= 1'b0;
    end else begin
      new_frame_out <= frame_end;
      if (frame_end) begin
        frame_collisions_out <= count_q;
        count_q              <= '0;
      end else if (active && is_collision && (count_q != COUNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_fsm.sv
// Game sequencer: start countdown, wall advance, collision loss and win decision per frame.
// Latency: state/depth/idx update 1 cycle after new_frame_out (2 after the frame-end pixel); start_in acts next cycle.
// Backpressure: none; SPEEDUP_EN shortens the frames-per-step for later walls.
module game_fsm
  import game_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS  = 1280,
  parameter int ACTIVE_LINES     = 720,
  parameter int MAX_WALL_DEPTH   = 75,
  parameter int GOAL_DEPTH_DELTA = 10,
  parameter int FRAMES_PER_STEP  = 4,
  parameter int COLLISION_THRESH = 2000,
  parameter int NUM_WALLS        = 8,
  parameter int START_FRAMES     = 120
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                is_collision,
  input  logic [DEPTH_W-1:0]  player_depth_in,
  input  logic                start_in,
  output game_state_t         game_state_out,
  output logic [DEPTH_W-1:0]  wall_depth_out,
  output logic [IDX_W-1:0]    wall_idx_out,
  output logic [COUNT_W-1:0]  frame_collisions_out,
  output logic                new_frame_out
);

  localparam logic [DEPTH_W-1:0] DEPTH_RELOAD = DEPTH_W'(MAX_WALL_DEPTH);

  logic               frame_end;
  logic               new_frame;
  logic [COUNT_W-1:0] frame_coll;
  logic [DEPTH_W-1:0] player_q;

  game_state_t        state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CDOWN_W-1:0] cdown_q, cdown_d;

  logic [STEP_W-1:0]  steps_eff;
  logic [DEPTH_W:0]   depth_gap;
  logic               in_window;
  logic               too_many;
  logic [IDX_W-1:0]   idx_next;

  collision_accumulator #(
    .ACTIVE_H_PIXELS (ACTIVE_H_PIXELS),
    .ACTIVE_LINES    (ACTIVE_LINES)
  ) u_accum (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .hcount_in            (hcount_in),
    .vcount_in            (vcount_in),
    .is_collision         (is_collision),
    .frame_end            (frame_end),
    .new_frame_out        (new_frame),
    .frame_collisions_out (frame_coll)
  );

  // Player depth is captured only at the frame end so the decision one cycle later uses that sample.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      player_q <= '0;
    end else if (frame_end) begin
      player_q <= player_depth_in;
    end
  end

  // Frames per wall step; later walls may step faster when speedup is built in.
  always_comb begin
    steps_eff = STEP_W'(FRAMES_PER_STEP);
`ifdef SPEEDUP_EN
    if ((FRAMES_PER_STEP - int'(idx_q)) > 1) begin
      steps_eff = STEP_W'(FRAMES_PER_STEP - int'(idx_q));
    end else begin
      steps_eff = STEP_W'(1);
    end
`endif
  end

  assign depth_gap = depth_abs_diff(depth_q, player_q);
  assign in_window = (depth_gap <= (DEPTH_W + 1)'(GOAL_DEPTH_DELTA));
  assign too_many  = (frame_coll > COUNT_W'(COLLISION_THRESH));
  assign idx_next  = idx_q + 1'b1;

  // Game state register and per-game counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= GAME_START;
      depth_q <= DEPTH_RELOAD;
      idx_q   <= '0;
      step_q  <= '0;
      cdown_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      cdown_q <= cdown_d;
    end
  end

  // Next-state logic; every frame decision is taken on the cycle new_frame is high.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    idx_d   = idx_q;
    step_d  = step_q;
    cdown_d = cdown_q;
    case (state_q)
      GAME_START: begin
        if (new_frame) begin
          if (cdown_q == CDOWN_W'(START_FRAMES - 1)) begin
            state_d = GAME_IN_PROGRESS;
            cdown_d = '0;
            step_d  = '0;
          end else begin
            cdown_d = cdown_q + 1'b1;
          end
        end
      end
      GAME_IN_PROGRESS: begin
        if (new_frame) begin
          // Loss is checked against the pre-update depth and beats any clear/win this frame.
          if (in_window && too_many) begin
            state_d = GAME_OVER;
          end else if (({1'b0, step_q} + 1'b1) >= {1'b0, steps_eff}) begin
            step_d = '0;
            if (depth_q == DEPTH_W'(1)) begin
              idx_d = idx_next;
              if (idx_next == IDX_W'(NUM_WALLS)) begin
                state_d = GAME_WIN;
                depth_d = '0;
              end else begin
                depth_d = DEPTH_RELOAD;
              end
            end else begin
              depth_d = depth_q - 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      GAME_OVER, GAME_WIN: begin
        if (start_in) begin
          state_d = GAME_START;
          depth_d = DEPTH_RELOAD;
          idx_d   = '0;
          step_d  = '0;
          cdown_d = '0;
        end
      end
      default: begin
        state_d = GAME_START;
        depth_d = DEPTH_RELOAD;
        idx_d   = '0;
        step_d  = '0;
        cdown_d = '0;
      end
    endcase
  end

  assign game_state_out       = state_q;
  assign wall_depth_out       = depth_q;
  assign wall_idx_out         = idx_q;
  assign frame_collisions_out = frame_coll;
  assign new_frame_out        = new_frame;

endmodule
